// File: rtl/bus_pkg.sv
// bus_pkg -- shared definitions for the CPU-to-device bus bridge.
//
// Contents:
//   state_t   : bridge FSM states (IDLE, ACCESS, RESP, ERR)
//   DEF_BASE  : default address of device slot 0
//   DEF_SPAN  : default bytes per device slot
//   WSEL_HI/LO: address bit range forming the device word select (ADD_O)
//   WSEL_W    : width of the word select
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE = 32'h0000_7F00;
  localparam int          DEF_SPAN = 16;

  localparam int WSEL_HI = 3;
  localparam int WSEL_LO = 2;
  localparam int WSEL_W  = WSEL_HI - WSEL_LO + 1;

endpackage

// File: rtl/bus_bridge_if.sv
// bus_bridge_if -- CPU-side and device-side bus signals of the bridge.
//
// Parameter:
//   NDEV : number of device slots
// CPU side:
//   cpu_req, cpu_we, cpu_addr, cpu_wdata  (CPU -> bridge)
//   cpu_rdata, cpu_ack, cpu_err, err_addr (bridge -> CPU)
// Device side:
//   ADD_O, DAT_O, STB_O, WE_O             (bridge -> devices)
//   DAT_I                                 (devices -> bridge, slot i at [32i+31:32i])
// Modports:
//   slave  : the bridge's view
//   master : the CPU / device-model view
interface bus_bridge_if
  import bus_pkg::*;
#(
  parameter int NDEV = 4
) ();

  logic                   cpu_req;
  logic                   cpu_we;
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [31:0]            cpu_rdata;
  logic                   cpu_ack;
  logic                   cpu_err;
  logic [31:0]            err_addr;

  logic [WSEL_W-1:0]      ADD_O;
  logic [31:0]            DAT_O;
  logic [NDEV-1:0]        STB_O;
  logic [NDEV-1:0]        WE_O;
  logic [32*NDEV-1:0]     DAT_I;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, DAT_I,
    output cpu_rdata, cpu_ack, cpu_err, err_addr,
    output ADD_O, DAT_O, STB_O, WE_O
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, DAT_I,
    input  cpu_rdata, cpu_ack, cpu_err, err_addr,
    input  ADD_O, DAT_O, STB_O, WE_O
  );

endinterface

// File: rtl/irq_sync.sv
// irq_sync -- per-bit register chain conditioning device interrupt lines.
//
// Parameters:
//   WIDTH  : number of interrupt lines
//   STAGES : number of flops in the chain (output latency in cycles, >= 1)
// Ports:
//   CLK_I  : clock, rising edge
//   RST_I  : asynchronous active-high reset, clears every stage
//   i_irq  : raw interrupt lines
//   o_irq  : conditioned interrupt lines
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [WIDTH-1:0] i_irq,
  output logic [WIDTH-1:0] o_irq
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_irq;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_irq = r_stage[STAGES-1];

endmodule

// File: rtl/bus_bridge.sv
// bus_bridge -- single-outstanding CPU to multi-device bridge.
//
// A CPU request sampled in IDLE is decoded against NDEV slots of SPAN bytes
// starting at BASE. Mapped requests strobe one device for one cycle and are
// acknowledged the cycle after; unmapped or misaligned requests skip the
// strobe and are answered with cpu_err, recording the faulting address.
//
// Parameters:
//   NDEV : number of device slots
//   BASE : address of slot 0
//   SPAN : bytes per slot
// Ports:
//   CLK_I   : clock, rising edge
//   RST_I   : asynchronous active-high reset
//   bus     : bus_bridge_if.slave (CPU handshake + device bus)
//   IRQ_I   : device interrupt lines, active-high level
//   HWINT_O : conditioned interrupt lines to the CPU
// Configuration macro:
//   BRIDGE_IRQ_SYNC_EN : when defined, interrupts pass a two-flop
//                        synchronizer; otherwise a single register stage.
module bus_bridge
  import bus_pkg::*;
#(
  parameter int          NDEV = 4,
  parameter logic [31:0] BASE = DEF_BASE,
  parameter int          SPAN = DEF_SPAN
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  bus_bridge_if.slave     bus,
  input  logic [NDEV-1:0] IRQ_I,
  output logic [NDEV-1:0] HWINT_O
);

  state_t          r_state;
  state_t          w_nextState;

  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [NDEV-1:0] r_sel;

  logic [31:0]     w_off;
  logic [31:0]     w_slotIdx;
  logic            w_mapped;
  logic [NDEV-1:0] w_sel;
  logic [31:0]     w_rdSlice;

  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic [31:0]     r_errAddr;

  // Address decode. The lower-bound compare guards against the subtraction
  // wrapping for addresses below BASE.
  always_comb begin
    w_off     = bus.cpu_addr - BASE;
    w_slotIdx = w_off / 32'(SPAN);
    w_mapped  = (bus.cpu_addr >= BASE) &&
                (w_off < 32'(NDEV * SPAN)) &&
                (bus.cpu_addr[1:0] == 2'b00);
    w_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_sel[i] = w_mapped && (w_slotIdx == 32'(i));
    end
  end

  // Request capture; the decoded slot is held one-hot for the access cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
    end else if (r_state == ST_IDLE && bus.cpu_req) begin
      r_addr  <= bus.cpu_addr;
      r_wdata <= bus.cpu_wdata;
      r_we    <= bus.cpu_we;
      r_sel   <= w_sel;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.cpu_req) w_nextState = w_mapped ? ST_ACCESS : ST_ERR;
      ST_ACCESS: w_nextState = ST_RESP;
      ST_RESP:   w_nextState = ST_IDLE;
      ST_ERR:    w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset drops them immediately.
  always_comb begin
    bus.STB_O = '0;
    bus.WE_O  = '0;
    bus.DAT_O = r_wdata;
    bus.ADD_O = r_addr[WSEL_HI:WSEL_LO];
    if (r_state == ST_ACCESS) begin
      bus.STB_O = r_sel;
      if (r_we) begin
        bus.WE_O = r_sel;
      end
    end
  end

  always_comb begin
    w_rdSlice = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (r_sel[i]) begin
        w_rdSlice = w_rdSlice | bus.DAT_I[32*i +: 32];
      end
    end
  end

  // Responses are registered from the state that produces them: ack is
  // loaded at the end of ACCESS and is therefore high during RESP; err and
  // err_addr are loaded at the end of ERR. Both land two cycles after the
  // request was sampled, and only one state can load them at a time.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_errAddr <= '0;
    end else begin
      r_ack <= (r_state == ST_ACCESS);
      r_err <= (r_state == ST_ERR);
      if (r_state == ST_ACCESS && !r_we) begin
        r_rdata <= w_rdSlice;
      end
      if (r_state == ST_ERR) begin
        r_errAddr <= r_addr;
      end
    end
  end

  assign bus.cpu_ack   = r_ack;
  assign bus.cpu_err   = r_err;
  assign bus.cpu_rdata = r_rdata;
  assign bus.err_addr  = r_errAddr;

`ifdef BRIDGE_IRQ_SYNC_EN
  localparam int IRQ_STAGES = 2;
`else
  localparam int IRQ_STAGES = 1;
`endif

  irq_sync #(
    .WIDTH  (NDEV),
    .STAGES (IRQ_STAGES)
  ) u_irqSync (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .i_irq (IRQ_I),
    .o_irq (HWINT_O)
  );

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 SHALL have parameter NDEV, default 4: number of device slots.
REQ-002 SHALL have parameter BASE, default 32'h0000_7F00: address of slot 0.
REQ-003 SHALL have parameter SPAN, default 16: bytes per slot; slot i = BASE+i*SPAN.
REQ-004 SHALL have port CLK_I  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port RST_I  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cpu_req  input  1  CPU access request, level, sampled in IDLE.
REQ-007 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cpu_addr  input  32  byte address.
REQ-009 SHALL have port cpu_wdata  input  32  write data.
REQ-010 SHALL have port cpu_rdata  output  32  registered read data.
REQ-011 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cpu_err  output  1  one-cycle error pulse, replaces ack.
REQ-013 SHALL have port err_addr  output  32  address of last faulting request.
REQ-014 SHALL have port ADD_O  output  2  device word select, address bits [3:2].
REQ-015 SHALL have port DAT_O  output  32  write data to devices.
REQ-016 SHALL have port STB_O  output  NDEV  one-hot device strobe.
REQ-017 SHALL have port WE_O  output  NDEV  one-hot device write enable.
REQ-018 SHALL have port DAT_I  input  32*NDEV  flattened device read data; slot i at bits [32i+31:32i].
REQ-019 SHALL have port IRQ_I  input  NDEV  device interrupt lines, active-high level.
REQ-020 SHALL have port HWINT_O  output  NDEV  conditioned interrupt lines to CPU.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-022 SHALL, in IDLE with cpu_req=1: latch addr, wdata and we; decode; go to ACCESS if mapped, else ERR.
REQ-023 SHALL treat a request as mapped only when BASE <= addr < BASE+NDEV*SPAN and addr[1:0]==0.
REQ-024 SHALL, in ACCESS: drive STB_O one-hot for the decoded slot and WE_O likewise if write, for exactly one cycle; DAT_O/ADD_O from latched values.
REQ-025 SHALL, in ACCESS on read, capture the selected DAT_I slice into cpu_rdata at the end of that cycle; writes leave cpu_rdata unchanged.
REQ-026 SHALL, in RESP, assert cpu_ack for one cycle, then return to IDLE.
REQ-027 SHALL, in ERR, assert cpu_err for one cycle, load err_addr with the latched address, drive no STB_O/WE_O, then return to IDLE.
REQ-028 SHALL give latency: request sampled in cycle N, strobe N+1, ack or err in N+2; max one access per 3 cycles.
REQ-029 SHALL ignore cpu_req in ACCESS, RESP and ERR; a request still held in the cycle after ack is accepted as a new access.
REQ-030 SHALL hold STB_O, WE_O at zero outside ACCESS.
REQ-031 SHALL never assert cpu_ack and cpu_err in the same cycle.

Reset
REQ-032 SHALL, on RST_I, go to IDLE immediately and zero cpu_rdata, cpu_ack, cpu_err, err_addr, STB_O, WE_O, DAT_O, ADD_O, HWINT_O and all sync flops.
REQ-033 SHALL abort an in-flight access on reset with no ack or err ever issued for it.

Configuration
REQ-034 SHALL honour macro BRIDGE_IRQ_SYNC_EN: when defined, IRQ_I reaches HWINT_O through a two-flop synchronizer, 2-cycle latency.
REQ-035 SHALL, without BRIDGE_IRQ_SYNC_EN, pass IRQ_I through one register stage, 1-cycle latency.

Structure
REQ-036 SHALL place the state enum, default BASE/SPAN constants and the word-select bit range in shared package bus_pkg.
REQ-037 SHALL implement interrupt conditioning in sub-module irq_sync, parameterised by width and stage count.

Verification
REQ-038 SHALL cover: write 0x0000_0009 to 0x7F00 -> STB_O=0001, WE_O=0001, ADD_O=0, DAT_O=9 in N+1; cpu_ack in N+2.
REQ-039 SHALL cover: read 0x7F18 with device 1 slice = 0xDEAD_BEEF -> STB_O=0010, ADD_O=2, WE_O=0; cpu_rdata=0xDEAD_BEEF with ack.
REQ-040 SHALL cover: read 0x7F40 (unmapped) and 0x7F02 (misaligned) -> no strobe, cpu_err in N+2, err_addr = 0x7F40 then 0x7F02.
REQ-041 SHALL cover: cpu_req held high 9 cycles -> exactly 3 acks, at cycles 2, 5, 8.
REQ-042 SHALL cover: RST_I pulsed in ACCESS cycle -> STB_O drops asynchronously; no ack; FSM in IDLE.
REQ-043 SHALL cover: IRQ_I[2] rises -> HWINT_O[2] rises after 2 cycles with BRIDGE_IRQ_SYNC_EN, after 1 cycle without.
